// File: rtl/mem_read_responder.sv
// mem_read_responder: single-port word memory with a fixed-latency pipelined read response
// Optional feature macro: MEM_BURST_EN (line burst reads with a busy back-pressure flag)
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   enable, wr, burst  request strobe, write select, burst-read select (burst used with MEM_BURST_EN)
//   addr, data_in      byte address (bit 0 ignored), write data
//   data_out           returning read word, 0 when data_valid=0
//   data_valid         data_out holds a read response this cycle
//   busy               burst in progress, requests dropped (constant 0 without MEM_BURST_EN)
module mem_read_responder #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int LATENCY   = 4,
   parameter int BURST_LEN = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              wr,
   input  logic              burst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              busy
);
   localparam int IW = ADDR_W - 1;
   localparam int OW = $clog2(BURST_LEN);
   logic [DATA_W-1:0] mem [2**IW];
   logic [IW-1:0] rd_idx;
   logic rd_go, wr_go;
   logic [LATENCY-1:0] pipe_v;
   logic [DATA_W-1:0] pipe_d [LATENCY];
   logic unused_ok;
`ifdef MEM_BURST_EN
   typedef enum logic {IDLE, BURST} state_t;
   state_t state;
   logic [OW-1:0] off;
   logic [IW-OW-1:0] base_hi;
   logic start;
   assign start = enable && !wr && burst && !busy && !rst;
   // During a burst the FSM owns the read port; the first word issues on the starting edge itself.
   assign rd_go = busy || (enable && !wr && !rst);
   assign rd_idx = busy ? {base_hi, off} : start ? {addr[ADDR_W-1:OW+1], {OW{1'b0}}} : addr[ADDR_W-1:1];
   assign wr_go = enable && wr && !busy && !rst;
   assign unused_ok = &{1'b0, addr[0]};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         off     <= '0;
         base_hi <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            state   <= BURST;
            busy    <= 1'b1;
            off     <= OW'(1);
            base_hi <= addr[ADDR_W-1:OW+1];
         end
      end else begin
         // Offset wraps back to 0 on the last word, leaving it ready for the next burst.
         off <= off + 1'b1;
         if (&off) begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end
   end
`else
   assign busy = 1'b0;
   assign rd_go = enable && !wr && !rst;
   assign rd_idx = addr[ADDR_W-1:1];
   assign wr_go = enable && wr && !rst;
   assign unused_ok = &{1'b0, burst, addr[0], OW[0]};
`endif
   always_ff @(posedge clk) begin
      if (wr_go) mem[addr[ADDR_W-1:1]] <= data_in;
   end
   // Word is captured at the accepting edge, so later writes cannot alter an in-flight read.
   // Invalid slots carry zero data so data_out is 0 whenever data_valid is 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v     <= '0;
         for (int i = 0; i < LATENCY; i++) pipe_d[i] <= '0;
         data_valid <= 1'b0;
         data_out   <= '0;
      end else begin
         pipe_v[0] <= rd_go;
         pipe_d[0] <= rd_go ? mem[rd_idx] : '0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
         data_valid <= pipe_v[LATENCY-1];
         data_out   <= pipe_d[LATENCY-1];
      end
   end
endmodule

// File: tb/tb_mem_read_responder.sv
// tb_mem_read_responder: scoreboard bench for mem_read_responder
module tb_mem_read_responder;
   localparam int LAT = 4;
   localparam int BL = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic wr = 1'b0;
   logic burst = 1'b0;
   logic [15:0] addr = '0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic data_valid;
   logic busy;
   typedef struct {int due; logic [15:0] d;} exp_t;
   exp_t q[$];
   logic [15:0] model [32768];
   int cyc = 0;
   int total = 0;
   int bad = 0;
   int busy_lo = 1;
   int busy_hi = 0;

   mem_read_responder dut (
      .clk(clk), .rst(rst), .enable(enable), .wr(wr), .burst(burst),
      .addr(addr), .data_in(data_in), .data_out(data_out),
      .data_valid(data_valid), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due == cyc) begin
         total++;
         if (data_valid !== 1'b1 || data_out !== q[0].d) begin
            bad++;
            $display("FAIL resp edge=%0d got valid=%b data=%h want valid=1 data=%h", cyc, data_valid, data_out, q[0].d);
         end
         void'(q.pop_front());
      end else begin
         total++;
         if (data_valid !== 1'b0 || data_out !== 16'h0) begin
            bad++;
            $display("FAIL idle edge=%0d got valid=%b data=%h want valid=0 data=0000", cyc, data_valid, data_out);
         end
      end
      total++;
      if (busy !== (cyc >= busy_lo && cyc <= busy_hi)) begin
         bad++;
         $display("FAIL busy edge=%0d got %b want %b", cyc, busy, (cyc >= busy_lo && cyc <= busy_hi));
      end
   end

   task automatic req(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d, input logic push);
      @(negedge clk);
      enable = 1'b1; wr = w; burst = b; addr = a; data_in = d;
      if (push) begin
         if (w) model[a[15:1]] = d;
         else q.push_back('{due: cyc + 1 + LAT, d: model[a[15:1]]});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         enable = 1'b0; wr = 1'b0; burst = 1'b0;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      total++;
      if (data_valid !== 1'b0 || data_out !== 16'h0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got valid=%b data=%h busy=%b want 0/0000/0", data_valid, data_out, busy);
      end
      rst = 1'b0;
   endtask

   task automatic test_single;
      req(1, 0, 16'h0010, 16'hBEEF, 1);
      req(0, 0, 16'h0010, 16'h0, 1);
      idle(7);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 8; i++) req(1, 0, 16'(2 * i), 16'(16'hA000 + i), 1);
      for (int i = 0; i < 8; i++) req(0, 0, 16'(2 * i), 16'h0, 1);
      idle(8);
   endtask

   task automatic test_snapshot;
      req(1, 0, 16'h0020, 16'h1111, 1);
      req(0, 0, 16'h0020, 16'h0, 1);
      req(1, 0, 16'h0020, 16'h2222, 1);
      req(0, 0, 16'h0020, 16'h0, 1);
      idle(7);
   endtask

   task automatic test_odd_addr;
      req(1, 0, 16'h0010, 16'h5A5A, 1);
      req(1, 0, 16'hFFFE, 16'h7E7E, 1);
      req(0, 0, 16'h0011, 16'h0, 1);
      req(0, 0, 16'hFFFF, 16'h0, 1);
      req(1, 0, 16'h0003, 16'h3C3C, 1);
      req(0, 0, 16'h0002, 16'h0, 1);
      idle(7);
   endtask

   task automatic test_reset_inflight;
      int ta;
      req(1, 0, 16'h0040, 16'h4444, 1);
      req(0, 0, 16'h0010, 16'h0, 1);
      ta = cyc + 1;
      req(0, 0, 16'h0040, 16'h0, 1);
      idle(1);
      while (cyc < ta + LAT) @(negedge clk);
      #2;
      q.delete();
      rst = 1'b1;
      #1;
      total++;
      if (data_valid !== 1'b0 || data_out !== 16'h0) begin
         bad++;
         $display("FAIL async_reset got valid=%b data=%h want 0/0000", data_valid, data_out);
      end
      enable = 1'b1; wr = 1'b1; addr = 16'h0040; data_in = 16'hDEAD;
      repeat (2) @(negedge clk);
      rst = 1'b0; enable = 1'b1; wr = 1'b0; burst = 1'b0; addr = 16'h0040;
      q.push_back('{due: cyc + 1 + LAT, d: model[15'h0020]});
      idle(10);
   endtask

   task automatic test_burst;
      int t;
      for (int i = 0; i < 8; i++) req(1, 0, 16'(16'h0030 + 2 * i), 16'(16'h00C0 + i), 1);
`ifdef MEM_BURST_EN
      req(0, 1, 16'h0036, 16'h0, 0);
      t = cyc + 1;
      for (int i = 0; i < BL; i++) q.push_back('{due: t + LAT + i, d: model[15'h0018 + 15'(i)]});
      busy_lo = t;
      busy_hi = t + BL - 2;
      idle(2);
      req(0, 0, 16'h0030, 16'h0, 0);
      idle(3);
      req(0, 0, 16'h0030, 16'h0, 0);
      req(0, 0, 16'h0032, 16'h0, 1);
`else
      t = 0;
      req(0, 1, 16'h0036, 16'h0, 1);
      req(0, 1, 16'h0038, 16'h0, 1);
`endif
      idle(1);
      if (t < 0) $display("unreachable");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_snapshot();
      test_odd_addr();
      test_reset_inflight();
      test_burst();
      for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
      idle(2);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d pending responses want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
